mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported unified RAM between the datapath's instruction-fetch and data-access request lines.
- Sits between the datapath cache interface signals (imemREN/dmemREN/dmemWEN, addresses, store data) and the RAM port.
- Sequences each access through a small grant state machine and returns ihit/dhit pulses.
- Data accesses take priority over fetches; a watchdog counter flags a stalled RAM.

Parameters:
- TIMEOUT, 255: max cycles a granted access may wait for ram_ready before the sticky error is set; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the wait counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- imemREN  in  1  instruction read request; held until ihit.
- imemaddr  in  32  fetch address, word aligned.
- imemload  out  32  fetch data; valid in the ihit cycle.
- ihit  out  1  one-cycle fetch-complete pulse.
- dmemREN  in  1  data read request; held until dhit.
- dmemWEN  in  1  data write request; held until dhit.
- dmemaddr  in  32  data address.
- dmemstore  in  32  write data.
- dmemload  out  32  read data; valid in the dhit cycle.
- dhit  out  1  one-cycle data-complete pulse.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ram_ready  in  1  RAM completes the presented access this cycle.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- States:
  - IDLE: no grant.
  - DGNT: data access granted.
  - IGNT: fetch granted.
  - TURN: one-cycle turnaround after each completion.
- Reset: state=IDLE, wait counter=0, timeout_err=0.
- Outputs during reset cycle and in IDLE/TURN: ramREN=ramWEN=0, ramaddr=0, ramstore=0, ihit=dhit=0.
- IDLE transitions:
  - dmemREN|dmemWEN goes to DGNT, even if imemREN is also high (data priority).
  - Else imemREN goes to IGNT.
  - Else stay in IDLE.
- DGNT outputs:
  - ramaddr=dmemaddr, ramstore=dmemstore, ramREN=dmemREN, ramWEN=dmemWEN.
  - dmemREN and dmemWEN both high: treat as write only (ramREN=0).
  - When ram_ready=1: dhit=1 and dmemload=ramload in that same cycle; next state TURN.
- IGNT outputs:
  - ramaddr=imemaddr, ramREN=1.
  - When ram_ready=1: ihit=1 and imemload=ramload; next state TURN.
- TURN:
  - Lasts one cycle with no RAM strobes, so a requester's stale strobe is never regranted.
  - Next state is IDLE.
- Best-case latency: request seen in IDLE at cycle 0, granted cycle 1, hit in cycle 1 if ram_ready=1.
- Back-to-back throughput: one access per 3 cycles.
- Request dropped mid-grant (abnormal; requester must hold until hit): no RAM strobes driven, state stays, counter keeps running.
- imemload/dmemload outside their hit cycles: hold 0.
- Wait counter:
  - Cleared on entry to DGNT/IGNT.
  - Increments each granted cycle with ram_ready=0, saturating at 2^CNT_W-1.
  - Reaching TIMEOUT sets timeout_err=1; it stays set until RST.
  - The grant is not aborted.
- RST asserted mid-access: the next edge returns to IDLE; no hit is issued for the aborted access.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- When defined: a 2-bit streak counter counts consecutive DGNT grants made while imemREN was pending. After 3 such grants, the next arbitration in IDLE grants IGNT regardless of data requests. Any IGNT grant clears the counter.
- When undefined: strict data priority; streak logic absent.

Test Plan:
- Reset: RST=1 for 2 cycles with all requests high -> all RAM strobes, hits and timeout_err are 0; first grant occurs in the cycle after RST falls.
- Single fetch: imemREN=1, imemaddr=0x40, ram_ready=1, ramload=0x8C010004 -> ramaddr=0x40 in cycle 1; ihit pulse in cycle 1 with imemload=0x8C010004; TURN, then IDLE.
- Simultaneous requests: imemREN=1 and dmemWEN=1 with dmemaddr=0x100, dmemstore=0xDEADBEEF -> data served first (ramWEN=1, dhit), then fetch granted after TURN; ihit 3 cycles after dhit.
- Wait states: grant a read with ram_ready low for 5 cycles -> strobes held stable for 6 cycles; dhit only in the 6th; timeout_err stays 0.
- Timeout: TIMEOUT=4, ram_ready held 0 -> timeout_err=1 after the 4th waiting cycle; stays 1 after ram_ready rises; cleared only by RST.
- Fairness (MEM_ARB_FAIR_EN defined): imemREN and dmemREN continuously high -> grant order D,D,D,I,D,D,D,I; macro undefined -> no IGNT ever.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates one RAM port between fetch and data requests, data first
// Defining MEM_ARB_FAIR_EN grants a waiting fetch after three data grants that bypassed it.
module mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic [31:0] imemload,
  output logic        ihit,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, DGNT = 2'd1, IGNT = 2'd2, TURN = 2'd3} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, cnt_inc;
  logic             dreq, granted, fair_turn;

  assign dreq    = dmemREN | dmemWEN;
  assign granted = (state == DGNT) || (state == IGNT);
  assign cnt_inc = (&wait_cnt) ? wait_cnt : wait_cnt + CNT_W'(1);

`ifdef MEM_ARB_FAIR_EN
  logic [1:0] streak;

  assign fair_turn = (streak == 2'd3) && imemREN;

  // Counts data grants that overtook a pending fetch; saturates at 3.
  always_ff @(posedge CLK) begin
    if (RST) begin
      streak <= '0;
    end else if (state == IDLE && state_next == IGNT) begin
      streak <= '0;
    end else if (state == IDLE && state_next == DGNT && imemREN && streak != 2'd3) begin
      streak <= streak + 2'd1;
    end
  end
`else
  assign fair_turn = 1'b0;
`endif

  always_comb begin
    state_next = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    ihit       = 1'b0;
    dhit       = 1'b0;
    imemload   = '0;
    dmemload   = '0;
    if (!RST) begin
      case (state)
        IDLE: begin
          if (fair_turn)    state_next = IGNT;
          else if (dreq)    state_next = DGNT;
          else if (imemREN) state_next = IGNT;
        end
        DGNT: begin
          ramaddr  = dmemaddr;
          ramstore = dmemstore;
          // A dropped request leaves the grant parked with strobes off.
          if (dreq) begin
            ramWEN = dmemWEN;
            ramREN = dmemREN & ~dmemWEN;
            if (ram_ready) begin
              dhit       = 1'b1;
              dmemload   = ramload;
              state_next = TURN;
            end
          end
        end
        IGNT: begin
          ramaddr = imemaddr;
          if (imemREN) begin
            ramREN = 1'b1;
            if (ram_ready) begin
              ihit       = 1'b1;
              imemload   = ramload;
              state_next = TURN;
            end
          end
        end
        TURN:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_next;
      if (!granted) begin
        wait_cnt <= '0;
      end else if (!ram_ready) begin
        wait_cnt <= cnt_inc;
        if (cnt_inc >= TIMEOUT_C) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter: directed timing plus random traffic
module tb_mem_arbiter;

  localparam int TO = 6;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = '0;
  logic [31:0] imemload;
  logic        ihit;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic [31:0] dmemaddr = '0;
  logic [31:0] dmemstore = '0;
  logic [31:0] dmemload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic        ram_ready = 1'b0;
  logic        timeout_err;

  bit ram_auto  = 1'b0;
  bit dir_ready = 1'b0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } dexp_t;

  logic [31:0] fq[$];
  dexp_t       dq[$];
  bit          oq[$];
  logic [31:0] shadow[0:127];
  logic [31:0] mem[0:127];

  int n_chk  = 0;
  int n_fail = 0;

  mem_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .imemREN(imemREN), .imemaddr(imemaddr), .imemload(imemload), .ihit(ihit),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .dmemload(dmemload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h8C01_0004 ^ ((a ^ 32'h40) << 12);
  endfunction

  function automatic logic [31:0] dinit(input logic [31:0] a);
    return 32'hA5A5_0000 | a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // RAM model: writes land on completion, reads return current contents.
  initial begin
    int lat = 0;
    int waited = 0;
    for (int i = 0; i < 128; i++) begin
      mem[i]    = (i < 64) ? rom(32'(i * 4)) : dinit(32'(i * 4));
      shadow[i] = dinit(32'(i * 4));
    end
    forever begin
      @(negedge CLK);
      if (!RST && ramWEN && ram_ready) mem[ramaddr[8:2]] = ramstore;
      @(posedge CLK);
      #2;
      if (ram_auto) begin
        if (ramREN || ramWEN) begin
          if (waited >= lat) begin
            ram_ready = 1'b1;
            waited    = 0;
            lat       = $urandom_range(0, 3);
          end else begin
            ram_ready = 1'b0;
            waited++;
          end
        end else begin
          ram_ready = 1'b0;
        end
      end else begin
        ram_ready = dir_ready;
      end
      ramload = mem[ramaddr[8:2]];
    end
  end

  // Monitor: every hit consumes the oldest expectation of its port.
  always @(negedge CLK) begin
    if (!RST) begin
      check("strobe_exclusive", 32'(ramREN & ramWEN), 32'd0);
      if (ihit) begin
        check("ihit_expected", 32'(fq.size() != 0), 32'd1);
        if (fq.size() != 0) check("imemload", imemload, fq.pop_front());
        check("ihit_strobe", 32'(ramREN), 32'd1);
      end else begin
        check("imemload_idle", imemload, 32'd0);
      end
      if (dhit) begin
        check("dhit_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) begin
          dexp_t e;
          e = dq.pop_front();
          check("dhit_ramaddr", ramaddr, e.addr);
          if (e.we) begin
            check("write_ramWEN", 32'(ramWEN), 32'd1);
            check("write_ramREN", 32'(ramREN), 32'd0);
            check("write_ramstore", ramstore, e.data);
          end else begin
            check("read_ramREN", 32'(ramREN), 32'd1);
            check("read_dmemload", dmemload, e.data);
          end
        end
      end else begin
        check("dmemload_idle", dmemload, 32'd0);
      end
      if ((ihit || dhit) && oq.size() != 0) check("grant_order_is_fetch", 32'(ihit), 32'(oq.pop_front()));
    end
  end

  task automatic fetch_agent(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      bit got;
      logic [31:0] a;
      r = $urandom_range(0, 2);
      repeat (r) step();
      a = 32'($urandom_range(0, 63)) * 4;
      imemaddr = a;
      imemREN  = 1'b1;
      fq.push_back(rom(a));
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
        @(negedge CLK);
        got = ihit;
      end
      check("fetch_agent_hit", 32'(got), 32'd1);
      step();
      imemREN = 1'b0;
    end
  endtask

  task automatic data_agent(input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      bit got;
      logic we, both;
      logic [31:0] a, s;
      r = $urandom_range(0, 2);
      repeat (r) step();
      we   = 1'($urandom_range(0, 1));
      both = we & ($urandom_range(0, 3) == 0);
      a    = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      s    = $urandom;
      dmemaddr  = a;
      dmemstore = s;
      dmemWEN   = we;
      dmemREN   = ~we | both;
      if (we) begin
        dq.push_back('{1'b1, a, s});
        shadow[a[8:2]] = s;
      end else begin
        dq.push_back('{1'b0, a, shadow[a[8:2]]});
      end
      got = 1'b0;
      for (int k = 0; k < 300 && !got; k++) begin
        @(negedge CLK);
        got = dhit;
      end
      check("data_agent_hit", 32'(got), 32'd1);
      step();
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
    end
  endtask

  initial begin
    int dc, ic, nh;
    bit fair;
`ifdef MEM_ARB_FAIR_EN
    fair = 1'b1;
`else
    fair = 1'b0;
`endif
    // Reset with every request raised.
    imemREN = 1'b1; dmemREN = 1'b1; dmemWEN = 1'b1;
    imemaddr = 32'h80; dmemaddr = 32'h100; dmemstore = 32'h1111_1111;
    dir_ready = 1'b1;
    @(posedge CLK);
    repeat (2) begin
      @(negedge CLK);
      check("rst_ramREN", 32'(ramREN), 32'd0);
      check("rst_ramWEN", 32'(ramWEN), 32'd0);
      check("rst_hits", 32'({ihit, dhit}), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
    end
    step();
    RST = 1'b0;
    dq.push_back('{1'b1, 32'h100, 32'h1111_1111});
    shadow[64] = 32'h1111_1111;
    @(negedge CLK);
    check("post_rst_idle", 32'(ramWEN), 32'd0);
    step();
    @(negedge CLK);
    check("first_grant_write", 32'(ramWEN), 32'd1);
    check("first_grant_dhit", 32'(dhit), 32'd1);
    step();
    imemREN = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
    repeat (3) step();

    // Single fetch, best-case latency.
    imemREN = 1'b1; imemaddr = 32'h40;
    fq.push_back(32'h8C01_0004);
    @(negedge CLK);
    check("fetch_c0_ihit", 32'(ihit), 32'd0);
    step();
    @(negedge CLK);
    check("fetch_c1_ramaddr", ramaddr, 32'h40);
    check("fetch_c1_ihit", 32'(ihit), 32'd1);
    step();
    imemREN = 1'b0;
    @(negedge CLK);
    check("fetch_turn_ramREN", 32'(ramREN), 32'd0);
    repeat (3) step();

    // Simultaneous requests: data first, fetch three cycles later.
    imemREN = 1'b1; imemaddr = 32'h44;
    dmemWEN = 1'b1; dmemaddr = 32'h100; dmemstore = 32'hDEAD_BEEF;
    dq.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF});
    shadow[64] = 32'hDEAD_BEEF;
    fq.push_back(rom(32'h44));
    dc = -1; ic = -1;
    for (int c = 0; c < 20 && ic < 0; c++) begin
      @(negedge CLK);
      if (dhit) dc = c;
      if (ihit) ic = c;
      step();
      if (dc >= 0) dmemWEN = 1'b0;
      if (ic >= 0) imemREN = 1'b0;
    end
    check("simul_data_cycle", 32'(dc), 32'd1);
    check("simul_fetch_gap", 32'(ic - dc), 32'd3);
    imemREN = 1'b0; dmemWEN = 1'b0;
    repeat (3) step();

    // Read with five wait states.
    dir_ready = 1'b0;
    dmemREN = 1'b1; dmemaddr = 32'h104;
    dq.push_back('{1'b0, 32'h104, shadow[65]});
    @(negedge CLK);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 6) dir_ready = 1'b1;
      @(negedge CLK);
      check("wait_ramREN", 32'(ramREN), 32'd1);
      check("wait_ramaddr", ramaddr, 32'h104);
      check("wait_dhit", 32'(dhit), 32'(c == 6));
    end
    step();
    dmemREN = 1'b0; dir_ready = 1'b0;
    @(negedge CLK);
    check("wait_no_timeout", 32'(timeout_err), 32'd0);
    repeat (3) step();

    // Random traffic against the scoreboard.
    ram_auto = 1'b1;
    fork
      fetch_agent(40);
      data_agent(60);
    join
    repeat (4) step();
    ram_auto = 1'b0;
    dir_ready = 1'b0;
    check("random_timeout_err", 32'(timeout_err), 32'd0);
    repeat (2) step();

    // Watchdog threshold and stickiness.
    dmemREN = 1'b1; dmemaddr = 32'h108;
    dq.push_back('{1'b0, 32'h108, shadow[66]});
    @(negedge CLK);
    for (int c = 1; c <= TO + 2; c++) begin
      step();
      @(negedge CLK);
      check("timeout_edge", 32'(timeout_err), 32'(c >= TO + 1));
    end
    step();
    dir_ready = 1'b1;
    @(negedge CLK);
    check("timeout_late_dhit", 32'(dhit), 32'd1);
    step();
    dmemREN = 1'b0; dir_ready = 1'b0;
    repeat (2) step();
    @(negedge CLK);
    check("timeout_sticky", 32'(timeout_err), 32'd1);

    // Reset mid-grant: no hit, error cleared.
    step();
    dmemREN = 1'b1; dmemaddr = 32'h10C;
    @(negedge CLK);
    step();
    @(negedge CLK);
    check("midrst_granted", 32'(ramREN), 32'd1);
    step();
    RST = 1'b1; dir_ready = 1'b1;
    @(negedge CLK);
    check("midrst_no_dhit", 32'(dhit), 32'd0);
    check("midrst_no_strobe", 32'(ramREN), 32'd0);
    step();
    RST = 1'b0; dmemREN = 1'b0;
    @(negedge CLK);
    check("midrst_err_clear", 32'(timeout_err), 32'd0);
    check("midrst_idle", 32'(ramREN), 32'd0);
    repeat (2) step();

    // Both requesters held high: grant order depends on fairness.
    imemREN = 1'b1; imemaddr = 32'h48;
    dmemREN = 1'b1; dmemaddr = 32'h110;
    for (int k = 0; k < 8; k++) begin
      if (fair && (k % 4 == 3)) begin
        fq.push_back(rom(32'h48));
        oq.push_back(1'b1);
      end else begin
        dq.push_back('{1'b0, 32'h110, shadow[68]});
        oq.push_back(1'b0);
      end
    end
    nh = 0;
    for (int c = 0; c < 60 && nh < 8; c++) begin
      @(negedge CLK);
      if (ihit || dhit) nh++;
      step();
    end
    imemREN = 1'b0; dmemREN = 1'b0; dir_ready = 1'b0;
    check("order_hit_count", 32'(nh), 32'd8);
    repeat (3) step();

    check("fetch_queue_drained", 32'(fq.size()), 32'd0);
    check("data_queue_drained", 32'(dq.size()), 32'd0);
    check("order_queue_drained", 32'(oq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
